shot_reaper: RTL and testbench
==============================

# shot_reaper

Retires shots held by the shot controller's slot array. It sweeps the `shots_data` bus one slot at a time and issues single-cycle `delete_shot`/`shot_address` pulses back to the shot controller when a live shot meets any of these conditions:
- it leaves the screen;
- it hits an asteroid, as reported over a request/acknowledge query to the asteroid controller;
- it exceeds its lifetime (optional).

It sits directly downstream of the shot controller and closes its delete loop.

## Interface
- `MAX_SHOTS`, 10, number of shot slots; must match the shot controller.
- `ENTITY_SIZE`, 34, width of one slot word.
- `SCREEN_W`, 640, x limit; a shot is on screen while x < `SCREEN_W`.
- `SCREEN_H`, 480, y limit; a shot is on screen while y < `SCREEN_H`.
- `MAX_AGE`, 200, lifetime in `move_clk` ticks (used only with `SHOT_LIFETIME_EN`).
- `AGE_W`, 8, width of each per-slot age counter.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-high reset.
- `move_clk`  in  1  movement tick, a one-`clk` pulse in the `clk` domain.
- `enable`  in  1  allows sweeping; while low, the FSM stays in or returns to `S_IDLE` once the current slot completes.
- `shots_data`  in  `MAX_SHOTS`×`ENTITY_SIZE`  slot array. Field layout:
  - [33] valid
  - [32:30] entity byte
  - [29:28] y queue
  - [27:26] x queue
  - [25:16] y
  - [15:6] x
  - [5:0] direction
- `query_req`  out  1  collision query request.
- `query_x`  out  10  shot x under query.
- `query_y`  out  10  shot y under query.
- `query_ack`  in  1  one-cycle query completion.
- `query_hit`  in  1  collision result, sampled only when `query_ack` is high.
- `delete_shot`  out  1  one-cycle delete strobe to the shot controller.
- `shot_address`  out  10  slot index to delete; meaningful while `delete_shot` is high.
- `hit_pulse`  out  1  one-cycle strobe on a confirmed asteroid hit (feeds scoring).
- `sweep_done`  out  1  one-cycle strobe when the index wraps from `MAX_SHOTS-1` to 0.

## Operation
- Slot index `idx` is a 10-bit register, reset to 0. It wraps from `MAX_SHOTS-1` to 0, and `sweep_done` pulses in the same cycle as the wrap.
- States: `S_IDLE`, `S_FETCH`, `S_CHECK`, `S_QUERY`, `S_DELETE`, `S_NEXT`.
- `S_IDLE`: moves to `S_FETCH` when `enable` is high.
- `S_FETCH`: latches `shots_data[idx]` into `cur_valid`, `cur_x` and `cur_y`.
- `S_CHECK` evaluates the latched slot:
  - `!cur_valid` → `S_NEXT`.
  - `cur_x >= SCREEN_W` or `cur_y >= SCREEN_H` → `S_DELETE`. The comparison is unsigned 10-bit, so an underflow from 0 to 1023 counts as off screen.
  - Aged out (see Configuration) → `S_DELETE`.
  - Otherwise → `S_QUERY`.
- `S_QUERY`:
  - `query_req` is high, and `query_x`/`query_y` hold the latched values stable until `query_ack`.
  - On `query_ack` with `query_hit` high, `hit_pulse` goes high in the next cycle and the FSM moves to `S_DELETE`.
  - On `query_ack` with `query_hit` low, the FSM moves to `S_NEXT`.
  - There is no timeout.
- `S_DELETE`: `delete_shot` is 1 and `shot_address` equals `idx` for exactly one cycle, then the FSM moves to `S_NEXT`.
- `S_NEXT`: advances `idx`, then goes to `S_FETCH` if `enable` is high, otherwise `S_IDLE`.
- Off-screen takes priority over age, and age takes priority over the query. An off-screen shot is never queried.
- Only this block clears slots, so a slot latched as valid cannot be reallocated before its `S_DELETE`.
- Outputs are registered. Reset values:
  - `query_req`, `delete_shot`, `hit_pulse`, `sweep_done` = 0.
  - `shot_address`, `query_x`, `query_y` = 0.
  - `idx` = 0, state = `S_IDLE`, all age counters = 0.
- Reset mid-query drops `query_req` on the next edge. A `query_ack` arriving during or after reset is ignored.

## Timing
- Cycles per slot, from `S_FETCH` entry to the next `S_FETCH` entry:
  - invalid slot: 3;
  - off-screen or aged: 4;
  - query miss: 3 + N, where N is the number of cycles `query_req` is high, N ≥ 1;
  - query hit: 4 + N.
- `query_req` rises in the cycle after `S_CHECK` and falls in the cycle after `query_ack` is sampled.
- `delete_shot` never asserts in two consecutive cycles.
- `delete_shot` and `hit_pulse` assert together for a hit.
- `delete_shot` asserts alone for an off-screen or aged shot.
- The shot controller clears the slot at the `clk` edge that samples `delete_shot`.

## Configuration
- `SHOT_LIFETIME_EN` defined:
  - `MAX_SHOTS` age counters, each `AGE_W` bits.
  - On `move_clk`, the counter of every valid slot increments, saturating at 2^`AGE_W`-1.
  - A slot's counter clears in any cycle where that slot is invalid, so a reallocated slot starts at 0.
  - `S_CHECK` treats `age[idx] >= MAX_AGE` as aged out.
- `SHOT_LIFETIME_EN` undefined:
  - No counters are built, `MAX_AGE` and `AGE_W` are unused, and shots never age out.

## Test plan
- Reset, then `enable`=1 with all slots invalid → `idx` cycles 0..9, `sweep_done` pulses every 30 cycles, and `delete_shot` never asserts.
- Slot 3 valid with x=1023, y=100 → `delete_shot`=1 with `shot_address`=3 for one cycle, no `query_req`, `hit_pulse`=0.
- Slot 5 valid with x=320, y=240; bench acks after 4 cycles with `query_hit`=1 → `query_x`=320 and `query_y`=240 stable for 4 cycles, then `delete_shot` and `hit_pulse` together with `shot_address`=5.
- Same as the previous scenario but `query_hit`=0 → no delete, and `idx` advances to 6.
- `SHOT_LIFETIME_EN`, `MAX_AGE`=3, slot 0 on screen, all queries missed, 3 `move_clk` pulses → slot 0 deleted on its next visit without a query.
- `reset_n` asserted while `query_req`=1, with a late `query_ack` → `query_req`=0 next cycle, FSM in `S_IDLE`, `idx`=0, no `delete_shot`.

Source files
------------

// File: rtl/shot_reaper.sv
// rtl/shot_reaper.sv - sweeps shot slots, deletes off-screen, hit and (with SHOT_LIFETIME_EN) aged-out shots
module shot_reaper #(
    parameter int MAX_SHOTS   = 10,
    parameter int ENTITY_SIZE = 34,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int MAX_AGE     = 200,
    parameter int AGE_W       = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             move_clk,
    input  logic                             enable,
    input  logic [MAX_SHOTS*ENTITY_SIZE-1:0] shots_data,
    output logic                             query_req,
    output logic [9:0]                       query_x,
    output logic [9:0]                       query_y,
    input  logic                             query_ack,
    input  logic                             query_hit,
    output logic                             delete_shot,
    output logic [9:0]                       shot_address,
    output logic                             hit_pulse,
    output logic                             sweep_done
);
    localparam int IDX_W = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
    localparam logic [9:0] LAST_IDX = 10'(MAX_SHOTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_QUERY,
        S_DELETE,
        S_NEXT
    } state_t;

    state_t           state;
    logic [9:0]       idx;
    logic             cur_valid;
    logic [9:0]       cur_x;
    logic [9:0]       cur_y;
    logic [IDX_W-1:0] slot;
    logic             off_screen;
    logic             aged;

    logic [ENTITY_SIZE-1:0] slot_word [MAX_SHOTS];
    logic [MAX_SHOTS-1:0]   slot_valid;
    logic [MAX_SHOTS-1:0]   unused_fields;

    genvar g;
    generate
        for (g = 0; g < MAX_SHOTS; g++) begin : g_slot
            assign slot_word[g]     = shots_data[g*ENTITY_SIZE +: ENTITY_SIZE];
            assign slot_valid[g]    = slot_word[g][33];
            assign unused_fields[g] = ^{slot_word[g][32:26], slot_word[g][5:0]};
        end
    endgenerate

    assign slot = idx[IDX_W-1:0];

    // 11-bit compare so a limit of 1024 still works; 0 - 1 wraps to 1023 and lands off screen
    assign off_screen = ({1'b0, cur_x} >= 11'(SCREEN_W)) || ({1'b0, cur_y} >= 11'(SCREEN_H));

`ifdef SHOT_LIFETIME_EN
    logic [AGE_W-1:0] age [MAX_SHOTS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_SHOTS; i++) begin
            if (reset_n) begin
                age[i] <= '0;
            end else if (!slot_valid[i]) begin
                age[i] <= '0;
            end else if (move_clk && (age[i] != '1)) begin
                age[i] <= age[i] + 1'b1;
            end
        end
    end

    assign aged = (32'(age[slot]) >= 32'(MAX_AGE));
`else
    logic unused_move;
    assign unused_move = move_clk;
    assign aged        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            cur_valid    <= 1'b0;
            cur_x        <= '0;
            cur_y        <= '0;
            query_req    <= 1'b0;
            query_x      <= '0;
            query_y      <= '0;
            delete_shot  <= 1'b0;
            shot_address <= '0;
            hit_pulse    <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            delete_shot <= 1'b0;
            hit_pulse   <= 1'b0;
            sweep_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) state <= S_FETCH;
                end
                S_FETCH: begin
                    cur_valid <= slot_valid[slot];
                    cur_x     <= slot_word[slot][15:6];
                    cur_y     <= slot_word[slot][25:16];
                    state     <= S_CHECK;
                end
                S_CHECK: begin
                    if (!cur_valid) begin
                        state <= S_NEXT;
                    end else if (off_screen || aged) begin
                        delete_shot  <= 1'b1;
                        shot_address <= idx;
                        state        <= S_DELETE;
                    end else begin
                        query_req <= 1'b1;
                        query_x   <= cur_x;
                        query_y   <= cur_y;
                        state     <= S_QUERY;
                    end
                end
                S_QUERY: begin
                    if (query_ack) begin
                        query_req <= 1'b0;
                        if (query_hit) begin
                            hit_pulse    <= 1'b1;
                            delete_shot  <= 1'b1;
                            shot_address <= idx;
                            state        <= S_DELETE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_DELETE: begin
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx == LAST_IDX) begin
                        idx        <= '0;
                        sweep_done <= 1'b1;
                    end else begin
                        idx <= idx + 10'd1;
                    end
                    state <= enable ? S_FETCH : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shot_reaper.sv
// tb/tb_shot_reaper.sv - scoreboard bench for shot_reaper
module tb_shot_reaper;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         move_clk;
    logic         enable;
    logic [339:0] shots_data;
    logic         query_req;
    logic [9:0]   query_x;
    logic [9:0]   query_y;
    logic         query_ack;
    logic         query_hit;
    logic         delete_shot;
    logic [9:0]   shot_address;
    logic         hit_pulse;
    logic         sweep_done;

    shot_reaper #(.MAX_AGE(3)) dut (
        .clk(clk), .reset_n(reset_n), .move_clk(move_clk), .enable(enable),
        .shots_data(shots_data), .query_req(query_req), .query_x(query_x),
        .query_y(query_y), .query_ack(query_ack), .query_hit(query_hit),
        .delete_shot(delete_shot), .shot_address(shot_address),
        .hit_pulse(hit_pulse), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] x; logic [9:0] y; int len; logic hit; } q_exp_t;
    typedef struct { logic [9:0] addr; logic hit; } d_exp_t;

    q_exp_t      qexp [$];
    d_exp_t      dexp [$];
    int          sweeps [$];
    logic [33:0] slots [10];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    bit          resp_on = 0;
    bit          resp_hit = 0;
    int          ack_delay = 4;

    always_comb begin
        for (int i = 0; i < 10; i++) shots_data[i*34 +: 34] = slots[i];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [33:0] mk(input logic v, input logic [9:0] x, input logic [9:0] y);
        return {v, 7'd0, y, x, 6'd0};
    endfunction

    // Monitor: pops expectations whenever the DUT presents a query or a delete
    int         qlen = 0;
    bit         unstable = 0;
    bit         prev_del = 0;
    logic [9:0] qx0, qy0;
    initial forever begin
        @(negedge clk);
        if (query_req) begin
            if (qlen == 0) begin
                if (qexp.size() == 0) check("unexpected_query", 1'b0, int'(query_x), -1);
                else begin
                    check("query_x", query_x == qexp[0].x, int'(query_x), int'(qexp[0].x));
                    check("query_y", query_y == qexp[0].y, int'(query_y), int'(qexp[0].y));
                end
                qx0 = query_x;
                qy0 = query_y;
            end else if (query_x != qx0 || query_y != qy0) begin
                unstable = 1;
            end
            qlen++;
        end else if (qlen != 0) begin
            if (qexp.size() != 0) begin
                check("query_len", qlen == qexp[0].len, qlen, qexp[0].len);
                check("query_stable", !unstable, int'(unstable), 0);
                check("delete_after_ack", delete_shot == qexp[0].hit, int'(delete_shot), int'(qexp[0].hit));
                void'(qexp.pop_front());
            end
            qlen = 0;
            unstable = 0;
        end
        if (delete_shot) begin
            check("no_back_to_back_delete", !prev_del, int'(prev_del), 0);
            if (dexp.size() == 0) check("unexpected_delete", 1'b0, int'(shot_address), -1);
            else begin
                check("delete_addr", shot_address == dexp[0].addr, int'(shot_address), int'(dexp[0].addr));
                check("delete_hit", hit_pulse == dexp[0].hit, int'(hit_pulse), int'(dexp[0].hit));
                void'(dexp.pop_front());
            end
            if (shot_address < 10) slots[shot_address][33] = 1'b0;
        end else if (hit_pulse) begin
            check("lone_hit_pulse", 1'b0, 1, 0);
        end
        prev_del = delete_shot;
        if (sweep_done) sweeps.push_back(cyc);
    end

    // Asteroid controller model: acks after ack_delay cycles of query_req
    int rcnt = 0;
    initial forever begin
        @(negedge clk);
        if (resp_on) begin
            if (query_ack) begin
                query_ack = 0;
                query_hit = 0;
                rcnt = 0;
            end else if (query_req) begin
                rcnt++;
                if (rcnt == ack_delay) begin
                    query_ack = 1;
                    query_hit = resp_hit;
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        reset_n = 1;
        enable = 0;
        resp_on = 0;
        query_ack = 0;
        query_hit = 0;
        for (int i = 0; i < 10; i++) slots[i] = '0;
        repeat (2) @(negedge clk);
        reset_n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1; enable = 0; move_clk = 0; query_ack = 0; query_hit = 0;
        for (int i = 0; i < 10; i++) slots[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_query_req", query_req == 0, int'(query_req), 0);
        check("rst_delete_shot", delete_shot == 0, int'(delete_shot), 0);
        check("rst_hit_pulse", hit_pulse == 0, int'(hit_pulse), 0);
        check("rst_sweep_done", sweep_done == 0, int'(sweep_done), 0);
        check("rst_shot_address", shot_address == 0, int'(shot_address), 0);
        check("rst_query_xy", query_x == 0 && query_y == 0, int'(query_x) + int'(query_y), 0);
        check("rst_idx", dut.idx == 0, int'(dut.idx), 0);

        // All slots empty: 3 cycles per slot, 30 per sweep
        reset_n = 0;
        enable = 1;
        sweeps.delete();
        repeat (100) @(negedge clk);
        enable = 0;
        check("sweep_count", sweeps.size() >= 3, sweeps.size(), 3);
        if (sweeps.size() >= 3) begin
            check("sweep_period_1", sweeps[1] - sweeps[0] == 30, sweeps[1] - sweeps[0], 30);
            check("sweep_period_2", sweeps[2] - sweeps[1] == 30, sweeps[2] - sweeps[1], 30);
        end

        // Off-screen shot in slot 3: deleted without a query
        reset_dut();
        slots[3] = mk(1'b1, 10'd1023, 10'd100);
        dexp.push_back('{addr: 10'd3, hit: 1'b0});
        enable = 1;
        repeat (40) @(negedge clk);
        enable = 0;
        repeat (5) @(negedge clk);
        check("offscreen_deleted", dexp.size() == 0, dexp.size(), 0);

        // Hit in slot 5 after a 4-cycle query
        reset_dut();
        slots[5] = mk(1'b1, 10'd320, 10'd240);
        resp_on = 1; resp_hit = 1; ack_delay = 4;
        qexp.push_back('{x: 10'd320, y: 10'd240, len: 4, hit: 1'b1});
        dexp.push_back('{addr: 10'd5, hit: 1'b1});
        enable = 1;
        repeat (45) @(negedge clk);
        enable = 0;
        repeat (5) @(negedge clk);
        check("hit_queue_empty", qexp.size() == 0 && dexp.size() == 0, qexp.size() + dexp.size(), 0);

        // Miss in slot 5: no delete, idx moves on to 6
        reset_dut();
        slots[5] = mk(1'b1, 10'd320, 10'd240);
        resp_on = 1; resp_hit = 0; ack_delay = 4;
        qexp.push_back('{x: 10'd320, y: 10'd240, len: 4, hit: 1'b0});
        enable = 1;
        begin
            bit seen = 0;
            bit done = 0;
            for (int i = 0; i < 80 && !done; i++) begin
                @(negedge clk);
                if (query_req) seen = 1;
                else if (seen) done = 1;
            end
            enable = 0;
            check("miss_query_done", done, int'(done), 1);
        end
        repeat (3) @(negedge clk);
        check("miss_idx", dut.idx == 6, int'(dut.idx), 6);
        check("miss_queue_empty", qexp.size() == 0, qexp.size(), 0);

`ifdef SHOT_LIFETIME_EN
        // Slot 0 ages out after 3 move ticks and is deleted without a query
        reset_dut();
        slots[0] = mk(1'b1, 10'd10, 10'd10);
        repeat (2) @(negedge clk);
        repeat (3) begin
            @(negedge clk) move_clk = 1;
            @(negedge clk) move_clk = 0;
        end
        dexp.push_back('{addr: 10'd0, hit: 1'b0});
        enable = 1;
        repeat (10) @(negedge clk);
        enable = 0;
        repeat (5) @(negedge clk);
        check("aged_deleted", dexp.size() == 0, dexp.size(), 0);
`endif

        // Reset during a query with a late ack
        reset_dut();
        slots[5] = mk(1'b1, 10'd100, 10'd100);
        qexp.push_back('{x: 10'd100, y: 10'd100, len: 3, hit: 1'b0});
        enable = 1;
        begin
            bit seen = 0;
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge clk);
                if (query_req) seen = 1;
            end
            check("reset_query_seen", seen, int'(seen), 1);
        end
        repeat (2) @(negedge clk);
        reset_n = 1; enable = 0; query_ack = 1; query_hit = 1;
        @(negedge clk);
        check("reset_drops_req", query_req == 0, int'(query_req), 0);
        check("reset_state_idle", 32'(dut.state) == 0, int'(dut.state), 0);
        check("reset_idx_zero", dut.idx == 0, int'(dut.idx), 0);
        reset_n = 0;
        @(negedge clk);
        query_ack = 0; query_hit = 0;
        repeat (10) @(negedge clk);
        check("reset_no_delete", dexp.size() == 0 && qexp.size() == 0, qexp.size() + dexp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
